// File: rtl/wb_uart_pkg.sv
// Shared constants for the wishbone UART responder: register offsets,
// STATUS bit positions and the bus FSM state encoding.
package wb_uart_pkg;

  // Register select values (addr_i[4:3])
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  // STATUS bit indices
  localparam int unsigned ST_TX_BUSY     = 0;
  localparam int unsigned ST_RX_EMPTY    = 1;
  localparam int unsigned ST_RX_FULL     = 2;
  localparam int unsigned ST_RX_OVERFLOW = 3;
  localparam int unsigned ST_RX_CNT_LSB  = 8;
  localparam int unsigned ST_RX_CNT_W    = 4;

  // Bus FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_WAIT = 2'd1,
    ACK     = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo_rx.sv
// Small synchronous circular-buffer FIFO for received UART bytes.
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i write side,
// pop_i read side with rd_data_c showing the head entry, flush_i empties the
// buffer (and wins over a same-cycle push). full_c/empty_c/overflow_c are
// combinational status; count_o is the registered fill level.
module sync_fifo_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic             overflow_c,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so push-while-full succeeds if popped
  always_comb begin
    full_c     = (count_q == (AW+1)'(DEPTH));
    empty_c    = (count_q == '0);
    do_pop     = pop_i & ~empty_c & ~flush_i;
    do_push    = push_i & ~flush_i & (~full_c | do_pop);
    overflow_c = push_i & ~flush_i & full_c & ~do_pop;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/wishbone_uart_slave.sv
// Wishbone classic responder exposing the UART in a 32-byte window.
// Ports: clk_i/rst_i (sync, active-high); wishbone addr_i/we_i/data_i/cyc_i/
// stb_i in, data_o/ack_o out; tx_data_o/tx_data_valid_o/tx_data_ready_i
// handshake to uart_tx; rx_data_i/rx_data_valid_i from uart_rx; irq_o high
// while received bytes are waiting.
module wishbone_uart_slave
  import wb_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned RX_DEPTH  = 4,
  parameter int unsigned RX_AW     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [63:0] data_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [63:0] data_o,
  output logic        ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_data_valid_o,
  input  logic        tx_data_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_data_valid_i,
  output logic        irq_o
);

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        ovf_q, ovf_d;
  logic        irq_q;

  logic        hit;
  logic [1:0]  sel;
  logic        rx_pop, rx_flush, ovf_clr, tx_load;
  logic [7:0]  rx_head;
  logic        rx_full, rx_empty, rx_ovf;
  logic [RX_AW:0] rx_count;
  logic [63:0] status;
  logic        unused_bits;

  sync_fifo_rx #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH),
    .AW    (RX_AW)
  ) u_rx_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (rx_data_valid_i),
    .din_i      (rx_data_i),
    .pop_i      (rx_pop),
    .flush_i    (rx_flush),
    .rd_data_c  (rx_head),
    .full_c     (rx_full),
    .empty_c    (rx_empty),
    .overflow_c (rx_ovf),
    .count_o    (rx_count)
  );

  assign hit = cyc_i & stb_i & (addr_i[31:5] == BASE_ADDR[31:5]);
  assign sel = addr_i[4:3];

  always_comb begin
    status = '0;
    status[ST_TX_BUSY]     = tx_valid_q;
    status[ST_RX_EMPTY]    = rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_RX_OVERFLOW] = ovf_q;
    status[ST_RX_CNT_LSB +: ST_RX_CNT_W] = ST_RX_CNT_W'(rx_count);
  end

  // Bus FSM; all register side effects fire on the edge that enters ACK
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    data_d     = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q & ~tx_data_ready_i;
    rx_pop     = 1'b0;
    rx_flush   = 1'b0;
    ovf_clr    = 1'b0;
    tx_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (we_i && (sel == REG_TXDATA) && tx_valid_q) begin
            state_d = TX_WAIT;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (we_i) begin
              case (sel)
                REG_TXDATA:  tx_load = 1'b1;
                REG_CONTROL: begin
                  ovf_clr  = data_i[0];
                  rx_flush = data_i[1];
                end
                default: ;
              endcase
            end else begin
              case (sel)
                REG_RXDATA: if (!rx_empty) begin
                  data_d = {55'b0, 1'b1, rx_head};
                  rx_pop = 1'b1;
                end
                REG_STATUS: data_d = status;
                default: ;
              endcase
            end
          end
        end
      end
      TX_WAIT: begin
        // Master gave up: abandon without ack or load
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (!tx_valid_q) begin
          state_d = ACK;
          ack_d   = 1'b1;
          tx_load = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tx_load) begin
      tx_data_d  = data_i[7:0];
      tx_valid_d = 1'b1;
    end
    // A fresh overflow outranks a same-cycle clear
    ovf_d = rx_ovf | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      data_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
      irq_q      <= ~rx_empty;
    end
  end

  assign ack_o           = ack_q;
  assign data_o          = data_q;
  assign tx_data_o       = tx_data_q;
  assign tx_data_valid_o = tx_valid_q;
  assign irq_o           = irq_q;

  // Address bits below word granularity and upper write-data bits carry no meaning
  assign unused_bits = ^{addr_i[2:0], data_i[63:8]};

endmodule

// File: tb/tb_wishbone_uart_slave.sv
// Directed self-checking bench for wishbone_uart_slave.
module tb_wishbone_uart_slave;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [63:0] data_i;
  logic        cyc_i;
  logic        stb_i;
  logic [63:0] data_o;
  logic        ack_o;
  logic [7:0]  tx_data_o;
  logic        tx_data_valid_o;
  logic        tx_data_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_data_valid_i;
  logic        irq_o;

  int n_cmp  = 0;
  int n_fail = 0;

  wishbone_uart_slave #(
    .BASE_ADDR (BASE),
    .RX_DEPTH  (4),
    .RX_AW     (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .addr_i          (addr_i),
    .we_i            (we_i),
    .data_i          (data_i),
    .cyc_i           (cyc_i),
    .stb_i           (stb_i),
    .data_o          (data_o),
    .ack_o           (ack_o),
    .tx_data_o       (tx_data_o),
    .tx_data_valid_o (tx_data_valid_o),
    .tx_data_ready_i (tx_data_ready_i),
    .rx_data_i       (rx_data_i),
    .rx_data_valid_i (rx_data_valid_i),
    .irq_o           (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Entered and left at 1 time unit after a rising edge; lat = -1 when no ack
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [63:0] wd,
                         input int budget, output logic [63:0] rd, output int lat);
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = a; we_i = w; data_i = wd;
    rd = '0; lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) begin rd = data_o; lat = n; break; end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data_i = b; rx_data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_data_valid_i = 1'b0;
  endtask

  task automatic tx_accept();
    tx_data_ready_i = 1'b1;
    @(posedge clk_i); #1;
    tx_data_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] rd; int lat;
    n_cmp++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    n_cmp++; if (data_o !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_o); end
    n_cmp++; if (tx_data_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got %b/%h want 0/00", tx_data_valid_o, tx_data_o); end
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    wb_xfer(BASE + 32'h10, 1'b0, '0, 10, rd, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL reset_status_lat: got %0d want 1", lat); end
    n_cmp++; if (rd !== 64'h2) begin n_fail++; $display("FAIL reset_status: got %h want 2", rd); end
    n_cmp++; if (data_o !== 64'h0 || ack_o !== 1'b0) begin n_fail++; $display("FAIL post_ack_clear: got %h/%b want 0/0", data_o, ack_o); end
  endtask

  task automatic test_tx_write();
    logic [63:0] rd; int lat;
    wb_xfer(BASE, 1'b1, 64'hFFFF_FFFF_FFFF_FF41, 10, rd, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL tx_lat: got %0d want 1", lat); end
    n_cmp++; if (tx_data_o !== 8'h41 || tx_data_valid_o !== 1'b1) begin n_fail++; $display("FAIL tx_load: got %h/%b want 41/1", tx_data_o, tx_data_valid_o); end
    repeat (10) @(posedge clk_i);
    #1;
    n_cmp++; if (tx_data_valid_o !== 1'b1) begin n_fail++; $display("FAIL tx_hold: got %b want 1", tx_data_valid_o); end
    tx_accept();
    n_cmp++; if (tx_data_valid_o !== 1'b0 || tx_data_o !== 8'h41) begin n_fail++; $display("FAIL tx_accept: got %b/%h want 0/41", tx_data_valid_o, tx_data_o); end
  endtask

  task automatic test_tx_stall();
    logic [63:0] rd; int lat; int early_acks; int ack_at;
    wb_xfer(BASE, 1'b1, 64'h41, 10, rd, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL stall_first_lat: got %0d want 1", lat); end
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = BASE; we_i = 1'b1; data_i = 64'h42;
    early_acks = 0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (ack_o === 1'b1) early_acks++;
    end
    n_cmp++; if (early_acks !== 0) begin n_fail++; $display("FAIL stall_no_ack: got %0d acks want 0", early_acks); end
    tx_data_ready_i = 1'b1;
    ack_at = -1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk_i); #1;
      tx_data_ready_i = 1'b0;
      if (ack_o === 1'b1) begin ack_at = n; break; end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    n_cmp++; if (ack_at !== 2) begin n_fail++; $display("FAIL stall_ack_lat: got %0d want 2", ack_at); end
    n_cmp++; if (tx_data_o !== 8'h42 || tx_data_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_byte: got %h/%b want 42/1", tx_data_o, tx_data_valid_o); end
    @(posedge clk_i); #1;
    tx_accept();
    n_cmp++; if (tx_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", tx_data_valid_o); end
  endtask

  task automatic test_rx_buffer();
    logic [63:0] rd; int lat;
    logic [63:0] exp_rd [4];
    exp_rd[0] = 64'h110; exp_rd[1] = 64'h120; exp_rd[2] = 64'h130; exp_rd[3] = 64'h0;
    rx_push(8'h10); rx_push(8'h20); rx_push(8'h30);
    @(posedge clk_i); #1;
    n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL rx_irq_set: got %b want 1", irq_o); end
    wb_xfer(BASE + 32'h10, 1'b0, '0, 10, rd, lat);
    n_cmp++; if (rd !== 64'h300) begin n_fail++; $display("FAIL rx_status3: got %h want 300", rd); end
    for (int i = 0; i < 4; i++) begin
      wb_xfer(BASE + 32'h08, 1'b0, '0, 10, rd, lat);
      n_cmp++; if (rd !== exp_rd[i] || lat !== 1) begin n_fail++; $display("FAIL rx_read%0d: got %h lat %0d want %h lat 1", i, rd, lat, exp_rd[i]); end
    end
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rx_irq_clr: got %b want 0", irq_o); end
  endtask

  task automatic test_rx_overflow();
    logic [63:0] rd; int lat;
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    wb_xfer(BASE + 32'h10, 1'b0, '0, 10, rd, lat);
    n_cmp++; if (rd !== 64'h40C) begin n_fail++; $display("FAIL ovf_status: got %h want 40c", rd); end
    for (int i = 1; i <= 4; i++) begin
      wb_xfer(BASE + 32'h08, 1'b0, '0, 10, rd, lat);
      n_cmp++; if (rd !== (64'h100 | 64'(i))) begin n_fail++; $display("FAIL ovf_read%0d: got %h want %h", i, rd, 64'h100 | 64'(i)); end
    end
    wb_xfer(BASE + 32'h10, 1'b0, '0, 10, rd, lat);
    n_cmp++; if (rd !== 64'h0A) begin n_fail++; $display("FAIL ovf_sticky: got %h want 0a", rd); end
    wb_xfer(BASE + 32'h18, 1'b1, 64'h1, 10, rd, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ctrl_lat: got %0d want 1", lat); end
    wb_xfer(BASE + 32'h10, 1'b0, '0, 10, rd, lat);
    n_cmp++; if (rd !== 64'h02) begin n_fail++; $display("FAIL ovf_cleared: got %h want 02", rd); end
  endtask

  task automatic test_push_pop_full();
    logic [63:0] rd; int lat;
    for (int i = 0; i < 4; i++) rx_push(8'hA0 + 8'(i));
    // Read pop and a new byte land on the same edge while the FIFO is full
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = BASE + 32'h08; we_i = 1'b0;
    rx_data_i = 8'hA4; rx_data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_data_valid_i = 1'b0;
    n_cmp++; if (ack_o !== 1'b1 || data_o !== 64'h1A0) begin n_fail++; $display("FAIL pp_read: got %b/%h want 1/1a0", ack_o, data_o); end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    wb_xfer(BASE + 32'h10, 1'b0, '0, 10, rd, lat);
    n_cmp++; if (rd !== 64'h404) begin n_fail++; $display("FAIL pp_status: got %h want 404", rd); end
    for (int i = 1; i <= 4; i++) begin
      wb_xfer(BASE + 32'h08, 1'b0, '0, 10, rd, lat);
      n_cmp++; if (rd !== (64'h1A0 + 64'(i))) begin n_fail++; $display("FAIL pp_drain%0d: got %h want %h", i, rd, 64'h1A0 + 64'(i)); end
    end
  endtask

  task automatic test_addr_miss();
    logic [63:0] rd; int lat;
    wb_xfer(BASE + 32'h20, 1'b0, '0, 6, rd, lat);
    n_cmp++; if (lat !== -1) begin n_fail++; $display("FAIL miss_read: got ack lat %0d want none", lat); end
    wb_xfer(BASE + 32'h20, 1'b1, 64'h77, 6, rd, lat);
    n_cmp++; if (lat !== -1 || tx_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_write: got lat %0d valid %b want none/0", lat, tx_data_valid_o); end
  endtask

  task automatic test_reset_tx_wait();
    logic [63:0] rd; int lat; int acks;
    wb_xfer(BASE, 1'b1, 64'h55, 10, rd, lat);
    n_cmp++; if (tx_data_valid_o !== 1'b1 || tx_data_o !== 8'h55) begin n_fail++; $display("FAIL rtw_load: got %b/%h want 1/55", tx_data_valid_o, tx_data_o); end
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = BASE; we_i = 1'b1; data_i = 64'h66;
    acks = 0;
    repeat (3) begin @(posedge clk_i); #1; if (ack_o === 1'b1) acks++; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    if (ack_o === 1'b1) acks++;
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; if (ack_o === 1'b1) acks++; end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rtw_ack: got %0d acks want 0", acks); end
    n_cmp++; if (tx_data_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin n_fail++; $display("FAIL rtw_tx: got %b/%h want 0/00", tx_data_valid_o, tx_data_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; addr_i = '0; we_i = 1'b0; data_i = '0; cyc_i = 1'b0; stb_i = 1'b0;
    tx_data_ready_i = 1'b0; rx_data_i = '0; rx_data_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_tx_write();
    test_tx_stall();
    test_rx_buffer();
    test_rx_overflow();
    test_push_pop_full();
    test_addr_miss();
    test_reset_tx_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
